// File: rtl/aes_encipher_pkg.sv
// aes_encipher_pkg: constants shared by the AES forward-cipher round core.
// Holds the round counts, key-length encodings, the FSM state type and the
// forward S-box table with its lookup function.
package aes_encipher_pkg;

  localparam logic [3:0] AES128_ROUNDS = 4'd10;
  localparam logic [3:0] AES256_ROUNDS = 4'd14;

  localparam logic KEYLEN_128 = 1'b0;
  localparam logic KEYLEN_256 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    MAIN  = 2'd2,
    FINAL = 2'd3
  } state_t;

  // Forward S-box, entry 0x00 in the most significant byte.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TABLE[11'd2047 - {b, 3'b000} -: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: 8-bit combinational forward S-box lookup.
// Ports: value (byte in), subst (substituted byte out).
module aes_sbox
  import aes_encipher_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] subst
);

  assign subst = sbox(value);

endmodule

// File: rtl/aes_encipher.sv
// aes_encipher: iterative AES forward-cipher core, one round per clock,
// AES-128 (10 rounds) or AES-256 (14 rounds).
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   next          - start request, sampled only in IDLE
//   keylen        - 0 = AES-128, 1 = AES-256, captured at accept
//   block         - plaintext, captured at accept
//   round         - registered index of the round key needed this cycle
//   round_key     - key memory response for round, same cycle
//   new_block     - state register; ciphertext while ready is high
//   ready         - result valid until the next request is accepted
module aes_encipher
  import aes_encipher_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         next,
  input  logic         keylen,
  input  logic [127:0] block,
  output logic [3:0]   round,
  input  logic [127:0] round_key,
  output logic [127:0] new_block,
  output logic         ready
);

  state_t       state_reg;
  logic [127:0] block_reg;
  logic [3:0]   round_reg;
  logic         keylen_reg;
  logic         ready_reg;

  logic [127:0] sub_bytes;
  logic [127:0] main_next;
  logic [127:0] final_next;
  logic [3:0]   num_rounds;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Bytes are column-major: byte n sits at [127-8n -: 8], row = n % 4.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    return {s[127:120], s[87:80],  s[47:40],   s[7:0],
            s[95:88],   s[55:48],  s[15:8],    s[103:96],
            s[63:56],   s[23:16],  s[111:104], s[71:64],
            s[31:24],   s[119:112], s[79:72],  s[39:32]};
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return {mix_column(s[127:96]), mix_column(s[95:64]),
            mix_column(s[63:32]),  mix_column(s[31:0])};
  endfunction

  function automatic logic [127:0] add_round_key(input logic [127:0] s,
                                                 input logic [127:0] k);
    return s ^ k;
  endfunction

  // SubBytes: one lookup per state byte.
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    aes_sbox u_sbox (
      .value (block_reg[8*i +: 8]),
      .subst (sub_bytes[8*i +: 8])
    );
  end

  assign main_next  = add_round_key(mix_columns(shift_rows(sub_bytes)), round_key);
  assign final_next = add_round_key(shift_rows(sub_bytes), round_key);
  assign num_rounds = (keylen_reg == KEYLEN_256) ? AES256_ROUNDS : AES128_ROUNDS;

  assign round     = round_reg;
  assign new_block = block_reg;
  assign ready     = ready_reg;

  // Round FSM: accept, initial key add, full rounds, final round.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      block_reg  <= 128'd0;
      round_reg  <= 4'd0;
      keylen_reg <= 1'b0;
      ready_reg  <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (next) begin
            block_reg  <= block;
            keylen_reg <= keylen;
            ready_reg  <= 1'b0;
            state_reg  <= INIT;
          end
        end
        INIT: begin
          block_reg <= add_round_key(block_reg, round_key);
          round_reg <= 4'd1;
          state_reg <= MAIN;
        end
        MAIN: begin
          block_reg <= main_next;
          round_reg <= round_reg + 4'd1;
          if (round_reg == num_rounds - 4'd1) begin
            state_reg <= FINAL;
          end
        end
        FINAL: begin
          block_reg <= final_next;
          ready_reg <= 1'b1;
          round_reg <= 4'd0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          round_reg <= 4'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_encipher.sv
// tb_aes_encipher: directed-vector bench for aes_encipher using FIPS-197
// known-answer vectors. The bench models the key memory: it expands the
// cipher key into a round-key table and returns the entry selected by round.
module tb_aes_encipher;
  import aes_encipher_pkg::*;

  localparam logic [127:0] KEY_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PT_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] INIT_B  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] CT_B    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KEY_C1  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [255:0] KEY_C3  =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C1   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_C3   = 128'h8ea2b7ca516745bfeafc49904b496089;

  logic         clk;
  logic         rst_n;
  logic         next;
  logic         keylen;
  logic [127:0] block;
  logic [3:0]   round;
  logic [127:0] round_key;
  logic [127:0] new_block;
  logic         ready;

  logic [127:0] rk_mem [0:15];
  int n_checks = 0;
  int n_pass   = 0;

  aes_encipher dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .next      (next),
    .keylen    (keylen),
    .block     (block),
    .round     (round),
    .round_key (round_key),
    .new_block (new_block),
    .ready     (ready)
  );

  assign round_key = rk_mem[round];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  // FIPS-197 key expansion into the round-key table.
  task automatic load_keys(input logic [255:0] key, input bit k256);
    logic [31:0] w [0:59];
    logic [31:0] t;
    logic [7:0]  rcon;
    int nk, total;
    nk    = k256 ? 8 : 4;
    total = k256 ? 60 : 44;
    for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
    rcon = 8'h01;
    for (int i = nk; i < total; i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h000000};
        rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
      end else if (nk == 8 && i % nk == 4) begin
        t = sub_word(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    for (int r = 0; r < 16; r++) rk_mem[r] = 128'd0;
    for (int r = 0; r < total / 4; r++)
      rk_mem[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One request: lat counts edges from the accept edge (1) to ready.
  task automatic do_req(input logic [127:0] blk, input logic kl, input bit hold,
                        input bit poke, output int lat, output logic [127:0] after_init,
                        output int seq_err, output int max_rnd);
    int exp_r;
    block  = blk;
    keylen = kl;
    next   = 1'b1;
    tick();
    lat = 1;
    if (!hold) next = 1'b0;
    if (poke) begin
      block  = ~blk;
      keylen = ~kl;
    end
    check("accept_drops_ready", {127'd0, ready}, 128'd0);
    seq_err    = 0;
    max_rnd    = 0;
    after_init = 128'd0;
    while (!ready && lat < 40) begin
      exp_r = (lat == 1) ? 0 : lat - 1;
      if (int'(round) != exp_r) seq_err++;
      if (int'(round) > max_rnd) max_rnd = int'(round);
      if (poke) next = (lat == 5);
      tick();
      lat++;
      if (lat == 2) after_init = new_block;
    end
    check("round_zero_at_ready", {124'd0, round}, 128'd0);
  endtask

  task automatic run_and_check(input string tag, input logic [127:0] blk, input logic kl,
                               input logic [127:0] exp, input bit hold, input bit poke);
    int lat, seq_err, max_rnd, nr;
    logic [127:0] ai;
    nr = kl ? 14 : 10;
    do_req(blk, kl, hold, poke, lat, ai, seq_err, max_rnd);
    check({tag, "_latency"}, 128'(lat), 128'(nr + 2));
    check({tag, "_result"}, new_block, exp);
    check({tag, "_round_seq"}, 128'(seq_err), 128'd0);
    check({tag, "_round_max"}, 128'(max_rnd), 128'(nr));
  endtask

  initial begin
    int lat, seq_err, max_rnd, guard, errs;
    logic [127:0] ai;

    next   = 1'b0;
    keylen = 1'b0;
    block  = 128'd0;
    for (int r = 0; r < 16; r++) rk_mem[r] = 128'd0;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    tick();
    tick();
    check("reset_ready", {127'd0, ready}, 128'd0);
    check("reset_new_block", new_block, 128'd0);
    check("reset_round", {124'd0, round}, 128'd0);
    rst_n = 1'b1;
    tick();

    // Appendix B: intermediate after INIT plus final result.
    load_keys({KEY_B, 128'd0}, 1'b0);
    do_req(PT_B, 1'b0, 1'b0, 1'b0, lat, ai, seq_err, max_rnd);
    check("B_after_init", ai, INIT_B);
    check("B_latency", 128'(lat), 128'd12);
    check("B_result", new_block, CT_B);

    // Appendix C.1 and C.3.
    load_keys({KEY_C1, 128'd0}, 1'b0);
    run_and_check("C1", PT_C, 1'b0, CT_C1, 1'b0, 1'b0);
    load_keys(KEY_C3, 1'b1);
    run_and_check("C3", PT_C, 1'b1, CT_C3, 1'b0, 1'b0);

    // next held high: second request accepted on the edge after ready rises.
    load_keys({KEY_C1, 128'd0}, 1'b0);
    run_and_check("hold1", PT_C, 1'b0, CT_C1, 1'b1, 1'b0);
    run_and_check("hold2", PT_C, 1'b0, CT_C1, 1'b0, 1'b0);

    // Busy-time next pulse and input toggles after accept are ignored.
    load_keys(KEY_C3, 1'b1);
    run_and_check("poke", PT_C, 1'b1, CT_C3, 1'b0, 1'b1);
    next = 1'b0;
    tick();
    check("poke_no_restart", {127'd0, ready}, 128'd1);

    // Reset during MAIN round 5.
    load_keys({KEY_C1, 128'd0}, 1'b0);
    block  = PT_C;
    keylen = 1'b0;
    next   = 1'b1;
    tick();
    next  = 1'b0;
    guard = 0;
    while (round != 4'd5 && guard < 40) begin
      tick();
      guard++;
    end
    check("reach_round5", {124'd0, round}, 128'd5);
    rst_n = 1'b0;
    #1;
    check("midrst_ready", {127'd0, ready}, 128'd0);
    check("midrst_new_block", new_block, 128'd0);
    check("midrst_round", {124'd0, round}, 128'd0);
    tick();
    tick();
    check("midrst_ready_held", {127'd0, ready}, 128'd0);
    rst_n = 1'b1;
    tick();
    run_and_check("after_rst", PT_C, 1'b0, CT_C1, 1'b0, 1'b0);

    // Idle hold: outputs stay put with no request.
    block  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    keylen = 1'b1;
    errs   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (ready !== 1'b1 || new_block !== CT_C1 || round !== 4'd0) errs++;
    end
    check("idle_hold", 128'(errs), 128'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_encipher.md
# aes_encipher

Iterative AES forward-cipher round core: one AES round per clock over a 128-bit state register, supporting AES-128 (10 rounds) and AES-256 (14 rounds). It sits beside the decipher core under the AES top level. It shares the same external key memory, which returns the round key selected by `round` combinationally in the same cycle. It uses the same `next`/`ready` request protocol, so the top level can mux the two cores onto one key schedule.

## Interface
- No parameters; round counts are fixed localparams (AES128_ROUNDS = 10, AES256_ROUNDS = 14).
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `next` in 1: start request; sampled only in IDLE.
- `keylen` in 1: 0 = AES-128, 1 = AES-256; captured at request accept.
- `block` in 128: plaintext; sampled only at request accept.
- `round` out 4: index of the round key required this cycle.
- `round_key` in 128: key-memory response for `round`, valid in the same cycle.
- `new_block` out 128: state register; ciphertext is valid while `ready` = 1.
- `ready` out 1: result valid; high from completion until the next request is accepted.

## Operation
- Byte order follows FIPS-197: `block[127:120]` = s[0,0], `block[119:112]` = s[1,0], and so on, column-major.
- Registers: `state_reg` (IDLE/INIT/MAIN/FINAL), `block_reg`[127:0], `round_reg`[3:0], `keylen_reg`, `ready_reg`.
- Nr = 14 if `keylen_reg` else 10.
- IDLE: `round` = 0. If `next` = 1: `block_reg` <= `block`, `keylen_reg` <= `keylen`, `ready_reg` <= 0, go to INIT. Otherwise everything holds, including `ready` and `new_block`.
- INIT (`round` = 0): `block_reg` <= `block_reg` ^ `round_key`; `round_reg` <= 1; go to MAIN.
- MAIN (`round` = r, 1 <= r <= Nr-1): `block_reg` <= MixColumns(ShiftRows(SubBytes(`block_reg`))) ^ `round_key`; `round_reg` <= r+1; go to FINAL when r = Nr-1, else stay in MAIN.
- FINAL (`round` = Nr): `block_reg` <= ShiftRows(SubBytes(`block_reg`)) ^ `round_key`; `ready_reg` <= 1; `round_reg` <= 0; go to IDLE.
- `next` is ignored outside IDLE.
- `keylen` and `block` changes after the accept edge have no effect.
- `round_reg` is 4 bits; its maximum value is 14, so it never wraps.
- Illegal state encodings go to IDLE with `round_reg` <= 0.

## Timing
- Reset values: `ready` = 0, `new_block` = 0, `round` = 0, state IDLE, `keylen_reg` = 0.
- Latency is Nr+2 rising edges from the edge that samples `next` = 1 to `ready` = 1: 12 cycles for AES-128, 16 cycles for AES-256.
- The accept edge drops `ready` to 0. During processing `new_block` shows intermediate round state and is not valid.
- `next` held high continuously: a new request is accepted on the first edge back in IDLE, which is one cycle after `ready` rises. `ready` is therefore high for exactly one cycle.
- A `next` pulse arriving while busy is lost; it is not queued.
- Reset asserted mid-operation returns all registers to reset values immediately. No partial result is exposed, and `ready` stays 0.
- `round` is a registered output with no combinational path from any input.

## Structure
- Shared constant file (the existing `constant` include): forward `sbox` table alongside `inv_sbox`; AES128_ROUNDS and AES256_ROUNDS; keylen encodings.
- Sub-module `aes_sbox`: 8-bit combinational lookup, instantiated 16 times for SubBytes.
- ShiftRows, MixColumns (xtime-based) and AddRoundKey are local functions.

## Test plan
- AES-128, FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, plaintext 3243f6a8885a308d313198a2e0370734.
  - `new_block` after INIT = 193de3bea0f4e22b9ac68d2ae9f84808.
  - `ready` 12 cycles after accept, with `new_block` = 3925841d02dc09fbdc118597196a0b32.
- AES-128, App. C.1: key 000102…0f, plaintext 00112233445566778899aabbccddeeff.
  - Result 69c4e0d86a7b0430d8cdb78070b4c55a.
  - `round` sequence 0,0,1,…,10,0.
- AES-256, App. C.3: key 000102…1f, same plaintext.
  - Result 8ea2b7ca516745bfeafc49904b496089 after 16 cycles.
  - `round` reaches 14.
- Back-to-back and busy-time requests:
  - `next` held high: the second C.1 request is accepted one cycle after `ready`; both results are correct.
  - `next` pulsed mid-operation, plus `block`/`keylen` toggled after accept: no effect on the result.
- Reset:
  - `rst_n` low at MAIN round 5: outputs are immediately 0/0/0.
  - A subsequent C.1 request completes correctly.
- Idle hold:
  - After completion with no `next`: `ready` and `new_block` hold for 20 cycles and `round` stays 0.
